// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - streaming 3x3 window generator with two line buffers
// Optional macro WIN3X3_LAST_EN adds win_last for the final window of a frame.
module window3x3_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] inLine1,
    output logic [23:0] inLine2,
    output logic [23:0] inLine3,
    output logic        out_valid,
    input  logic        out_ready
`ifdef WIN3X3_LAST_EN
    ,
    output logic        win_last
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0]   line1_q, line1_d;
    logic [23:0]   line2_q, line2_d;
    logic [23:0]   line3_q, line3_d;
    logic          out_valid_q, out_valid_d;
    logic          accept;
    logic          complete;
    logic [7:0]    lb_a_rd;
    logic [7:0]    lb_b_rd;

    logic [7:0] lb_a [IMG_W];
    logic [7:0] lb_b [IMG_W];

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign lb_a_rd  = lb_a[col_q];
    assign lb_b_rd  = lb_b[col_q];

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        line1_d     = line1_q;
        line2_d     = line2_q;
        line3_d     = line3_q;
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        if (accept) begin
            line1_d = {line1_q[15:0], lb_b_rd};
            line2_d = {line2_q[15:0], lb_a_rd};
            line3_d = {line3_q[15:0], pix_in};
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (complete) begin
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= '0;
            row_q       <= '0;
            line1_q     <= '0;
            line2_q     <= '0;
            line3_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            line1_q     <= line1_d;
            line2_q     <= line2_d;
            line3_q     <= line3_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Line buffers carry no reset; windows need two rows of the current frame first.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b[col_q] <= lb_a_rd;
            lb_a[col_q] <= pix_in;
        end
    end

    assign inLine1   = line1_q;
    assign inLine2   = line2_q;
    assign inLine3   = line3_q;
    assign out_valid = out_valid_q;

`ifdef WIN3X3_LAST_EN
    logic win_last_q, win_last_d;

    always_comb begin
        win_last_d = out_ready ? 1'b0 : win_last_q;
        if (complete) begin
            win_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_last_q <= 1'b0;
        end else begin
            win_last_q <= win_last_d;
        end
    end

    assign win_last = win_last_q;
`endif

endmodule
